// File: rtl/dft64_unloader.sv
// dft64_unloader
//   Captures one complete dft64 result frame (64 complex bins) on the `done`
//   pulse. It then streams bins 0..NBINS_OUT-1 out one per beat on a
//   valid/ready interface, so dft64 can start the next transform at once.
//
//   State table:
//     IDLE   | no frame held; waiting for `done`
//     STREAM | frame buffered; out_valid high, one bin per handshake
//
// Ports:
//   clk, sreset          clock, synchronous active-high reset
//   done                 dft64 result valid (realfft/imagfft valid this cycle)
//   realfft, imagfft     64 x DW signed bins, element k = bin k
//   out_valid/out_ready  output handshake
//   out_bin              bin index of the current beat
//   out_re, out_im       signed bin value
//   out_pow              unsigned re^2 + im^2 (2*DW+1 bits)
//   out_last             current beat is bin NBINS_OUT-1
//   busy                 frame buffered or streaming
//   overrun              sticky: a `done` arrived mid-frame and was dropped
module dft64_unloader #(
  parameter int DW        = 16,
  parameter int NBINS_OUT = 64
) (
  input  logic                   clk,
  input  logic                   sreset,
  input  logic                   done,
  input  logic [63:0][DW-1:0]    realfft,
  input  logic [63:0][DW-1:0]    imagfft,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_bin,
  output logic [DW-1:0]          out_re,
  output logic [DW-1:0]          out_im,
  output logic [2*DW:0]          out_pow,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [5:0] LAST_BIN = 6'(NBINS_OUT - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [63:0][DW-1:0] r_buf_re;
  logic [63:0][DW-1:0] r_buf_im;

  logic [5:0]    r_bin;
  logic [DW-1:0] r_re;
  logic [DW-1:0] r_im;
  logic [2*DW:0] r_pow;
  logic          r_overrun;

  logic                 w_hs;
  logic                 w_last_hs;
  logic                 w_capture;
  logic                 w_advance;
  logic                 w_drop;
  logic [5:0]           w_nxt_idx;
  logic [5:0]           w_sel_bin;
  logic signed [DW-1:0] w_sel_re;
  logic signed [DW-1:0] w_sel_im;
  logic signed [2*DW-1:0] w_re_sq;
  logic signed [2*DW-1:0] w_im_sq;
  logic [2*DW:0]        w_pow;

  // A done on the final handshake starts the next frame with no bubble;
  // a done at any other point in STREAM is dropped and flagged.
  always_comb begin
    w_hs      = (r_state == S_STREAM) && out_ready;
    w_last_hs = w_hs && (r_bin == LAST_BIN);
    w_capture = done && ((r_state == S_IDLE) || w_last_hs);
    w_advance = w_hs && !w_last_hs;
    w_drop    = done && (r_state == S_STREAM) && !w_last_hs;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (done) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_hs && !done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bin 0 of a new frame comes straight from the input bus because the
  // buffer is only written on the same edge.
  always_comb begin
    w_nxt_idx = r_bin + 6'd1;
    w_sel_bin = w_capture ? 6'd0 : w_nxt_idx;
    w_sel_re  = w_capture ? signed'(realfft[0]) : signed'(r_buf_re[w_nxt_idx]);
    w_sel_im  = w_capture ? signed'(imagfft[0]) : signed'(r_buf_im[w_nxt_idx]);
    w_re_sq   = w_sel_re * w_sel_re;
    w_im_sq   = w_sel_im * w_sel_im;
    // Squares are non-negative, so zero extension is exact; the sum can reach
    // 2^(2*DW-1) and needs the extra bit.
    w_pow     = {1'b0, w_re_sq} + {1'b0, w_im_sq};
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_re      <= '0;
      r_im      <= '0;
      r_pow     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture || w_advance) begin
        r_bin <= w_sel_bin;
        r_re  <= w_sel_re;
        r_im  <= w_sel_im;
        r_pow <= w_pow;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  // Frame storage carries no reset; its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (w_capture && !sreset) begin
      r_buf_re <= realfft;
      r_buf_im <= imagfft;
    end
  end

  always_comb begin
    out_valid = (r_state == S_STREAM);
    busy      = (r_state == S_STREAM);
    out_bin   = r_bin;
    out_re    = r_re;
    out_im    = r_im;
    out_pow   = r_pow;
    out_last  = out_valid && (r_bin == LAST_BIN);
    overrun   = r_overrun;
  end

endmodule

// File: doc/dft64_unloader.md
# dft64_unloader

Result-side counterpart to the sample loader that feeds `dft64`. On the `done` pulse it captures the 64 complex bins presented in parallel on `realfft`/`imagfft` into a local buffer. It then streams them out one bin per beat on a valid/ready interface, with bin index, last flag and per-bin power |X|². It sits between `dft64` and any downstream consumer (CSV dumper, peak detector, bus bridge), so `dft64` is free to start the next transform immediately.

## Interface
- `DW`, 16: signed width of each real/imag bin (fixed-point, per `rtl/fixedpoint.sv`).
- `NBINS_OUT`, 64: number of bins streamed, bins 0..NBINS_OUT-1; legal range 1..64 (33 for real-only input).
- `clk`  in  1  single clock; all logic on posedge.
- `sreset`  in  1  synchronous, active-high reset.
- `done`  in  1  `dft64` result valid; sampled each posedge.
- `realfft`  in  64 x DW  signed real part, element k = bin k.
- `imagfft`  in  64 x DW  signed imaginary part, element k = bin k.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts beat when high with `out_valid`.
- `out_bin`  out  6  bin index of current beat.
- `out_re`  out  DW  signed real part of bin `out_bin`.
- `out_im`  out  DW  signed imaginary part of bin `out_bin`.
- `out_pow`  out  2*DW+1  unsigned re² + im².
- `out_last`  out  1  high on the beat with `out_bin` == NBINS_OUT-1.
- `busy`  out  1  high while a frame is buffered or streaming.
- `overrun`  out  1  sticky; set when a `done` is dropped.

## Operation
- FSM states: IDLE, STREAM.
- IDLE: if `done`==1, copy all 64 real and 64 imag bins into the buffer, load output regs with bin 0, set bin counter = 0, go to STREAM. Otherwise hold.
- STREAM: `out_valid`=1. A handshake (`out_valid` & `out_ready`) advances the counter and loads output regs with the next bin.
- On the handshake with bin NBINS_OUT-1: if `done`==1 in that same cycle, recapture and restart at bin 0 with no bubble and no overrun. Otherwise go to IDLE.
- `done`==1 in STREAM in any other cycle: ignore the input (buffer untouched), set `overrun`=1.
- Outputs are registered and remain stable while `out_valid`=1 and `out_ready`=0.
- `out_pow` = re·re + im·im. Compute at full precision from the sign-extended buffer entry before the output register; no rounding, no saturation. Max value 2^(2*DW-1) fits 2*DW+1 bits.
- `busy` = (state == STREAM).
- `overrun` is cleared only by `sreset`.

## Timing
- Reset (`sreset`=1 at a posedge) gives state IDLE and all outputs 0: `out_valid`, `out_bin`, `out_re`, `out_im`, `out_pow`, `out_last`, `busy`, `overrun`. Buffer contents are don't-care.
- Reset mid-stream aborts the frame immediately. The next frame needs a fresh `done`.
- `done` sampled high at edge N (IDLE) gives `out_valid`=1, `out_bin`=0, `busy`=1 after edge N.
- Inputs must be valid only in the `done` cycle.
- Handshake at edge M gives the next bin visible after edge M. Throughput is 1 bin/cycle with `out_ready` held high, so a frame drains in NBINS_OUT cycles.
- Last handshake at edge L with no `done` gives `out_valid`=0 and `busy`=0 after edge L. A `done` at edge L+1 is accepted.
- `out_last` is combinational on `out_bin` and NBINS_OUT, qualified by `out_valid`.

## Test plan
- Ramp frame: real[k]=k, imag[k]=-k, one-cycle `done`, `out_ready`=1 -> 64 beats on consecutive cycles, bin k with re=k, im=-k, pow=2k²; `out_last` only at bin 63; `busy`=0 the cycle after.
- Backpressure: same frame with `out_ready` toggling 1,0,0,1,... -> no bin lost or repeated; outputs frozen while `out_ready`=0; exactly 64 handshakes.
- Overrun and back-to-back:
  - `done` at bin 10 -> `overrun`=1, streamed values unchanged.
  - Second frame (real[k]=100+k) with `done` on the bin-63 handshake -> next beat is bin 0, re=100, no bubble, `overrun` stays at its prior value.
- Extremes: real[5]=imag[5]=-32768, real[6]=32767, imag[6]=-32768 -> pow[5]=2147483648, pow[6]=2147418113.
- Reset mid-stream: `sreset` at bin 20 -> all outputs 0 next cycle; later `done` streams a fresh frame from bin 0.
- NBINS_OUT=33: ramp frame -> beats for bins 0..32 only, `out_last` at bin 32, IDLE after.
